input_conditioner: RTL and testbench

Input-side companion to the segment-display output path: takes the raw push-button and the slide-switch bank from the board pins, synchronises and debounces them in the 50 MHz domain, and presents clean levels, single-cycle event pulses, auto-repeat on long press, and a sticky press flag with acknowledge. The sticky flag lets slow consumers such as the 4 Hz counter FSM see every press. It sits between the board pins and the counter FSM's select/data inputs.

---
 rtl/input_conditioner.sv | 175 +++++++++++++++++
 tb/tb_input_conditioner.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Board-pin conditioner: synchronises and debounces the push-button and the
// slide-switch bank, and produces press/repeat/release pulses, a sticky press
// flag with acknowledge, and a debounced switch vector with change pulse.
`timescale 1ns/1ps
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 12500000,
  parameter int unsigned SW_WIDTH        = 8,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                btn_i,
  input  logic [SW_WIDTH-1:0] sw_i,
  input  logic                ack_i,
  output logic                btn_level_o,
  output logic                press_o,
  output logic                repeat_o,
  output logic                release_o,
  output logic                press_pend_o,
  output logic [SW_WIDTH-1:0] sw_o,
  output logic                sw_chg_o
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HOLD_W = $clog2(HR_MAX) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
  } state_t;

  logic                btn_s1, btn_s2;
  logic [SW_WIDTH-1:0] sw_s1, sw_s2;
  logic [DB_W-1:0]     btn_cnt;
  logic [DB_W-1:0]     sw_cnt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  state_t              state, state_nxt;
  logic                press_nxt, repeat_nxt, release_nxt;

  logic btn_norm_c, btn_diff_c, btn_toggle_c, rise_c, fall_c;
  logic sw_moving_c, sw_load_c;

  assign btn_norm_c   = btn_i ^ BTN_ACTIVE_LOW;
  assign btn_diff_c   = (btn_s2 != btn_level_o);
  assign btn_toggle_c = btn_diff_c && (btn_cnt == DB_LAST);
  assign rise_c       = btn_toggle_c && !btn_level_o;
  assign fall_c       = btn_toggle_c && btn_level_o;

  // The change is seen on the second stage's input so the stability window
  // starts in the same cycle the synchronised vector takes its new value.
  assign sw_moving_c  = (sw_s1 != sw_s2);
  assign sw_load_c    = !sw_moving_c && (sw_cnt == DB_LAST) && (sw_s2 != sw_o);

  // Two-flop synchronisers for the button (1 = pressed) and switch bank
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= btn_norm_c;
      btn_s2 <= btn_s1;
      sw_s1  <= sw_i;
      sw_s2  <= sw_s1;
    end
  end

  // Button debounce: count consecutive disagreeing cycles, flip level at the limit
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      btn_cnt     <= '0;
      btn_level_o <= 1'b0;
    end else begin
      if (!btn_diff_c || btn_toggle_c) btn_cnt <= '0;
      else                             btn_cnt <= btn_cnt + DB_W'(1);
      if (btn_toggle_c) btn_level_o <= !btn_level_o;
    end
  end

  // Button FSM state, hold counter and registered event pulses
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      press_o   <= 1'b0;
      repeat_o  <= 1'b0;
      release_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      press_o   <= press_nxt;
      repeat_o  <= repeat_nxt;
      release_o <= release_nxt;
    end
  end

  // Button FSM next state: release takes priority over a coincident repeat
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    press_nxt   = 1'b0;
    repeat_nxt  = 1'b0;
    release_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise_c) begin
          state_nxt = ST_PRESSED;
          press_nxt = 1'b1;
          hold_nxt  = '0;
        end
      end
      ST_PRESSED: begin
        if (fall_c) begin
          state_nxt   = ST_IDLE;
          release_nxt = 1'b1;
          hold_nxt    = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt  = ST_REPEAT;
          repeat_nxt = 1'b1;
          hold_nxt   = '0;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      ST_REPEAT: begin
        if (fall_c) begin
          state_nxt   = ST_IDLE;
          release_nxt = 1'b1;
          hold_nxt    = '0;
        end else if (hold_cnt == REP_LAST) begin
          repeat_nxt = 1'b1;
          hold_nxt   = '0;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  // Sticky press flag: a press/repeat pulse beats a coincident acknowledge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                   press_pend_o <= 1'b0;
    else if (press_o || repeat_o) press_pend_o <= 1'b1;
    else if (ack_i)               press_pend_o <= 1'b0;
  end

  // Switch debounce: saturating stability counter, load once on first reaching the limit
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sw_cnt   <= '0;
      sw_o     <= '0;
      sw_chg_o <= 1'b0;
    end else begin
      if (sw_moving_c)          sw_cnt <= '0;
      else if (sw_cnt != DB_MAX) sw_cnt <= sw_cnt + DB_W'(1);
      if (sw_load_c) sw_o <= sw_s2;
      sw_chg_o <= sw_load_c;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus random
// pin activity, every cycle compared against a history-based reference model.
`timescale 1ns/1ps
module tb_input_conditioner;

  localparam int unsigned D   = 4;
  localparam int unsigned H   = 20;
  localparam int unsigned R   = 8;
  localparam int unsigned SWW = 8;
  localparam int          N   = 8192;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           btn;
  logic [SWW-1:0] sw;
  logic           ack;
  logic           btn_level_o, press_o, repeat_o, release_o, press_pend_o, sw_chg_o;
  logic [SWW-1:0] sw_o;

  always #5 clk = ~clk;

  input_conditioner #(
    .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R),
    .SW_WIDTH(SWW), .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .btn_i(btn), .sw_i(sw), .ack_i(ack),
    .btn_level_o(btn_level_o), .press_o(press_o), .repeat_o(repeat_o),
    .release_o(release_o), .press_pend_o(press_pend_o),
    .sw_o(sw_o), .sw_chg_o(sw_chg_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: pin history per clock edge since reset, judged by the rules
  bit             bh [N];
  logic [SWW-1:0] sh [N];
  int             t;
  int             press_t;
  bit             m_level, m_press, m_rep, m_rel, m_pend, m_chg;
  logic [SWW-1:0] m_sw;
  int             n_press, n_rep, n_rel, n_chg;

  function automatic bit bget(int i);
    return (i < 1) ? 1'b0 : bh[i];
  endfunction

  function automatic logic [SWW-1:0] sget(int i);
    return (i < 1) ? '0 : sh[i];
  endfunction

  // True when the synchronised switch vector has held one value for D+1 samples
  function automatic bit sw_stable(int e);
    if (e < int'(D)) return 1'b0;
    for (int k = 0; k <= int'(D); k++)
      if (sget(e - 1 - k) !== sget(e - 1)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    t = 0; press_t = 0;
    m_level = 0; m_press = 0; m_rep = 0; m_rel = 0; m_pend = 0; m_chg = 0;
    m_sw = '0;
  endtask

  task automatic model_edge();
    bit toggle, lvl_old, p_old, r_old;
    int e;
    t++;
    if (t >= N - 1) begin
      $display("FAIL model_history t=%0d exceeds %0d", t, N);
      $fatal(1, "history overflow");
    end
    bh[t] = ~btn;
    sh[t] = sw;
    p_old = m_press;
    r_old = m_rep;
    // Level flips once D consecutive synchronised samples disagree with it
    toggle = 1'b1;
    for (int k = 0; k < int'(D); k++)
      if (bget(t - 2 - k) == m_level) toggle = 1'b0;
    lvl_old = m_level;
    m_press = toggle && !lvl_old;
    m_rel   = toggle && lvl_old;
    if (toggle) m_level = !m_level;
    if (m_press) press_t = t;
    m_rep = 1'b0;
    if (lvl_old && !toggle) begin
      e = t - press_t;
      if (e == int'(H) || (e > int'(H) && ((e - int'(H)) % int'(R)) == 0)) m_rep = 1'b1;
    end
    if (p_old || r_old) m_pend = 1'b1;
    else if (ack)       m_pend = 1'b0;
    m_chg = 1'b0;
    if (sw_stable(t) && !sw_stable(t - 1) && sget(t - 1) !== m_sw) begin
      m_chg = 1'b1;
      m_sw  = sget(t - 1);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic check_all();
    chk("btn_level", 32'(btn_level_o), 32'(m_level));
    chk("press", 32'(press_o), 32'(m_press));
    chk("repeat", 32'(repeat_o), 32'(m_rep));
    chk("release", 32'(release_o), 32'(m_rel));
    chk("press_pend", 32'(press_pend_o), 32'(m_pend));
    chk("sw", 32'(sw_o), 32'(m_sw));
    chk("sw_chg", 32'(sw_chg_o), 32'(m_chg));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_level"}, 32'(btn_level_o), 32'd0);
    chk({tag, "_press"}, 32'(press_o), 32'd0);
    chk({tag, "_repeat"}, 32'(repeat_o), 32'd0);
    chk({tag, "_release"}, 32'(release_o), 32'd0);
    chk({tag, "_pend"}, 32'(press_pend_o), 32'd0);
    chk({tag, "_sw"}, 32'(sw_o), 32'd0);
    chk({tag, "_chg"}, 32'(sw_chg_o), 32'd0);
  endtask

  // One clock: advance model on the edge, compare just after it
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (press_o)   n_press++;
    if (repeat_o)  n_rep++;
    if (release_o) n_rel++;
    if (sw_chg_o)  n_chg++;
  endtask

  task automatic clear_counts();
    n_press = 0; n_rep = 0; n_rel = 0; n_chg = 0;
  endtask

  initial begin
    int rep_offs[$];
    int rel_off;
    int btn_run;
    bit seen;

    rst_n = 1'b0; btn = 1'b1; sw = '0; ack = 1'b0;
    model_reset();
    clear_counts();
    #2;
    check_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) tick();

    // Clean press: pulse on the 6th edge after the pin change
    clear_counts();
    btn = 1'b0;
    repeat (5) tick();
    chk("press_early", 32'(n_press), 32'd0);
    tick();
    chk("press_at_6", 32'(press_o), 32'd1);
    chk("level_at_6", 32'(btn_level_o), 32'd1);
    tick();
    chk("pend_after_press", 32'(press_pend_o), 32'd1);
    repeat (3) tick();
    btn = 1'b1;
    repeat (5) tick();
    tick();
    chk("release_at_6", 32'(release_o), 32'd1);
    repeat (4) tick();
    chk("clean_press_count", 32'(n_press), 32'd1);
    chk("clean_release_count", 32'(n_rel), 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("lone_ack_clears", 32'(press_pend_o), 32'd0);
    repeat (4) tick();

    // Bounce: 3-cycle pulses never qualify, then a settled press
    clear_counts();
    for (int p = 0; p < 10; p++) begin
      btn = (p % 2 == 0) ? 1'b0 : 1'b1;
      repeat (3) tick();
    end
    btn = 1'b0;
    repeat (15) tick();
    chk("bounce_press_count", 32'(n_press), 32'd1);
    chk("bounce_release_count", 32'(n_rel), 32'd0);
    btn = 1'b1;
    repeat (12) tick();
    ack = 1'b1; tick(); ack = 1'b0;
    repeat (4) tick();

    // Auto-repeat with ack handshakes, released so the fall lands on a repeat slot
    clear_counts();
    btn = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (press_o) seen = 1'b1;
    end
    chk("repeat_press_seen", 32'(seen), 32'd1);
    rel_off = -1;
    for (int o = 1; o <= 60; o++) begin
      ack = (o == 24 || o == 29 || o == 32);
      btn = (o >= 47) ? 1'b1 : 1'b0;
      tick();
      if (repeat_o)  rep_offs.push_back(o);
      if (release_o) rel_off = o;
      if (o == 24) chk("ack_clears_pend", 32'(press_pend_o), 32'd0);
      if (o == 29) chk("set_beats_ack", 32'(press_pend_o), 32'd1);
      if (o == 32) chk("lone_ack_after_rep", 32'(press_pend_o), 32'd0);
    end
    ack = 1'b0;
    chk("repeat_count", 32'(rep_offs.size()), 32'd4);
    for (int i = 0; i < rep_offs.size() && i < 4; i++)
      chk("repeat_offset", 32'(rep_offs[i]), 32'(20 + 8 * i));
    chk("release_offset", 32'(rel_off), 32'd52);
    repeat (4) tick();

    // Switches: clean change, then a short glitch that must not register
    clear_counts();
    sw = 8'hA5;
    repeat (5) tick();
    tick();
    chk("sw_chg_at_6", 32'(sw_chg_o), 32'd1);
    chk("sw_value", 32'(sw_o), 32'hA5);
    repeat (8) tick();
    chk("sw_chg_count", 32'(n_chg), 32'd1);
    clear_counts();
    sw = 8'hA4;
    repeat (2) tick();
    sw = 8'hA5;
    repeat (12) tick();
    chk("glitch_chg_count", 32'(n_chg), 32'd0);
    chk("glitch_sw_value", 32'(sw_o), 32'hA5);

    // Random pin activity against the model
    btn_run = 1;
    for (int i = 0; i < 500; i++) begin
      btn_run--;
      if (btn_run <= 0) begin
        btn = ~btn;
        btn_run = int'($urandom_range(1, 40));
      end
      if ($urandom_range(0, 24) == 0) sw = SWW'($urandom);
      else if ($urandom_range(0, 39) == 0) sw = sw ^ SWW'(1 << $urandom_range(0, SWW - 1));
      ack = ($urandom_range(0, 4) == 0);
      tick();
    end
    btn = 1'b1; ack = 1'b0;
    repeat (20) tick();

    // Reset while auto-repeating, button held through reset
    btn = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (repeat_o) seen = 1'b1;
    end
    chk("reached_repeat", 32'(seen), 32'd1);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    clear_counts();
    repeat (5) tick();
    chk("post_reset_no_early_press", 32'(n_press), 32'd0);
    tick();
    chk("post_reset_press_at_6", 32'(press_o), 32'd1);
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so a stuck run still terminates
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
